multiple_add_elastic: RTL

MULTIPLE_ADD_ELASTIC -- requirements
Module: multiple_add_elastic

---
 rtl/multiple_add_pkg.sv | 19 +
 rtl/multiple_add_valid_pipe.sv | 31 +++
 rtl/multiple_add_elastic.sv | 70 +++++++
 3 files changed

// File: rtl/multiple_add_pkg.sv
// Shared helpers for the elastic multi-adder: per-adder constants and unsigned saturating add.
// Both functions work on 64-bit values; callers truncate to their own DATA_WIDTH (<= 64).
package multiple_add_pkg;

  function automatic logic [63:0] k_const(input longint base, input longint step, input int idx);
    return 64'(base + longint'(idx) * step);
  endfunction

  // Operands are already reduced to 'width' bits, so the 65-bit sum cannot overflow.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int width);
    logic [64:0] sum;
    logic [64:0] max_val;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = (65'd1 << width) - 65'd1;
    return (sum > max_val) ? max_val[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/multiple_add_valid_pipe.sv
// Resettable valid-bit shift chain with global hold and synchronous flush.
// Only these bits are reset; the data path beside them is reset-free.
module multiple_add_valid_pipe #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic advance,
  input  logic valid_in,
  output logic valid_out
);

  logic [STAGES-1:0] vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (clear) begin
      vld <= '0;
    end else if (advance) begin
      vld[0] <= valid_in;
      for (int j = 1; j < STAGES; j++) begin
        vld[j] <= vld[j-1];
      end
    end
  end

  assign valid_out = vld[STAGES-1];

endmodule

// File: rtl/multiple_add_elastic.sv
// Elastic pipeline adding one operand to NUM_ADDERS constants (BASE + i*STEP) in parallel.
// All stages move together on 'advance'; only the valid chain carries reset.
module multiple_add_elastic
  import multiple_add_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ADDERS = 64,
  parameter int LATENCY    = 3,
  parameter int BASE       = 0,
  parameter int STEP       = 1,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [DATA_WIDTH-1:0] out [NUM_ADDERS],
  output logic                  valid_out,
  input  logic                  ready_out
);

  logic                  advance;
  logic [DATA_WIDTH-1:0] x;

  assign advance  = !valid_out || ready_out;
  assign ready_in = advance;

  multiple_add_valid_pipe #(
    .STAGES(LATENCY)
  ) u_valid_pipe (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .advance  (advance),
    .valid_in (valid_in),
    .valid_out(valid_out)
  );

  // Operand delay line; with LATENCY=1 the adders read 'in' directly.
  if (LATENCY > 1) begin : g_ops
    logic [DATA_WIDTH-1:0] op_q [LATENCY-1];

    always_ff @(posedge clk) begin
      if (advance) begin
        op_q[0] <= in;
        for (int j = 1; j < LATENCY - 1; j++) begin
          op_q[j] <= op_q[j-1];
        end
      end
    end

    assign x = op_q[LATENCY-2];
  end else begin : g_direct
    assign x = in;
  end

  for (genvar i = 0; i < NUM_ADDERS; i++) begin : g_add
    localparam logic [DATA_WIDTH-1:0] K = DATA_WIDTH'(k_const(BASE, STEP, i));

    always_ff @(posedge clk) begin
      if (advance) begin
        out[i] <= (SATURATE != 0) ? DATA_WIDTH'(sat_add(64'(x), 64'(K), DATA_WIDTH))
                                  : x + K;
      end
    end
  end

endmodule
